// File: rtl/cd4532_pkg.sv
// cd4532_pkg: shared definitions for the CD4532-style priority encoder.
//   N_IN_DEFAULT     default number of request lines
//   N_IN_MAX/YW_MAX  widest supported request vector and its index width
//   cd4532_res_t     encoder result {y, gs, eo}
//   cd4532_msb_index highest-set-bit index of a vector (0 when all zeros)
package cd4532_pkg;

   localparam int unsigned N_IN_DEFAULT = 8;
   localparam int unsigned N_IN_MAX     = 64;
   localparam int unsigned YW_MAX       = 6;

   // y is sized for the widest instance; narrower instances use the low bits.
   typedef struct packed {
      logic [YW_MAX-1:0] y;
      logic              gs;
      logic              eo;
   } cd4532_res_t;

   function automatic logic [YW_MAX-1:0] cd4532_msb_index(input logic [N_IN_MAX-1:0] vec);
      logic [YW_MAX-1:0] idx;
      logic              found;
      idx   = '0;
      found = 1'b0;
      for (int k = N_IN_MAX - 1; k >= 0; k--) begin
         if (!found && vec[k]) begin
            found = 1'b1;
            idx   = YW_MAX'(k);
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/cd4532_prio_core.sv
// cd4532_prio_core: combinational CD4532 priority encoder.
//   N_IN  number of request lines (power of two, 2..64)
//   ei    enable in; 0 forces an all-zero result
//   i     request lines, bit N_IN-1 has highest priority
//   res   {y, gs, eo}: index of highest set bit, group select, enable out
module cd4532_prio_core
   import cd4532_pkg::*;
#(
   parameter int unsigned N_IN = N_IN_DEFAULT
) (
   input  logic            ei,
   input  logic [N_IN-1:0] i,
   output cd4532_res_t     res
);

   logic found;

   // Scan from MSB down; the first hit wins, lower bits are don't-care.
   always_comb begin
      res   = '0;
      found = 1'b0;
      for (int k = N_IN - 1; k >= 0; k--) begin
         if (!found && i[k]) begin
            found = 1'b1;
            res.y = YW_MAX'(k);
         end
      end
      res.gs = ei & found;
      res.eo = ei & ~found;
      if (!ei) begin
         res.y = '0;
      end
   end

endmodule

// File: rtl/cd4532_priority_encoder.sv
// cd4532_priority_encoder: registered 8-input (parameterisable) priority encoder
// reproducing the CD4532 truth table. Cascade wider encoders via EO -> EI.
//   clk  clock, rising edge
//   rst  synchronous active-high reset, clears every register
//   EI   enable in
//   I    request lines, bit N_IN-1 highest priority
//   Y    registered index of highest set request
//   GS   registered group select (enabled and some request set)
//   EO   registered enable out (enabled and no request set)
// Build option: define CD4532_INREG_EN to register EI/I before encoding
// (latency 2 clocks instead of 1).
module cd4532_priority_encoder
   import cd4532_pkg::*;
#(
   parameter int unsigned N_IN = N_IN_DEFAULT,
   parameter int unsigned YW   = $clog2(N_IN)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            EI,
   input  logic [N_IN-1:0] I,
   output logic [YW-1:0]   Y,
   output logic            GS,
   output logic            EO
);

   logic            ei_s;
   logic [N_IN-1:0] i_s;
   cd4532_res_t     res_d;
   cd4532_res_t     res_q;

`ifdef CD4532_INREG_EN
   logic            ei_q;
   logic [N_IN-1:0] i_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         ei_q <= 1'b0;
         i_q  <= '0;
      end else begin
         ei_q <= EI;
         i_q  <= I;
      end
   end

   assign ei_s = ei_q;
   assign i_s  = i_q;
`else
   assign ei_s = EI;
   assign i_s  = I;
`endif

   cd4532_prio_core #(
      .N_IN (N_IN)
   ) u_core (
      .ei  (ei_s),
      .i   (i_s),
      .res (res_d)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         res_q <= '0;
      end else begin
         res_q <= res_d;
      end
   end

   assign Y  = res_q.y[YW-1:0];
   assign GS = res_q.gs;
   assign EO = res_q.eo;

   // Upper index bits are always zero for narrow instances.
   logic unused_y_bits;
   assign unused_y_bits = ^res_q.y;

endmodule

// File: tb/tb_cd4532_priority_encoder.sv
module tb_cd4532_priority_encoder;

`ifdef CD4532_INREG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic       clk;
   logic       rst;
   logic       EI;
   logic [7:0] I;
   logic [2:0] Y;
   logic       GS;
   logic       EO;

   int n_cmp;
   int n_err;

   cd4532_priority_encoder #(
      .N_IN (8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .EI  (EI),
      .I   (I),
      .Y   (Y),
      .GS  (GS),
      .EO  (EO)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Advance one rising edge and sample 1 time unit later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_out(input string tag, input logic [2:0] ey, input logic egs,
                            input logic eeo);
      check({tag, ".Y"}, 32'(Y), 32'(ey));
      check({tag, ".GS"}, 32'(GS), 32'(egs));
      check({tag, ".EO"}, 32'(EO), 32'(eeo));
   endtask

   // Hold a vector for the pipeline latency, then check the result.
   task automatic apply(input string tag, input logic ei, input logic [7:0] req,
                        input logic [2:0] ey, input logic egs, input logic eeo);
      EI = ei;
      I  = req;
      repeat (LAT) step();
      check_out(tag, ey, egs, eeo);
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst   = 1'b1;
      EI    = 1'b1;
      I     = 8'hFF;
      #1;

      // Reset dominates active inputs.
      step();
      check_out("reset", 3'd0, 1'b0, 1'b0);
      step();
      check_out("reset_hold", 3'd0, 1'b0, 1'b0);
      rst = 1'b0;
      repeat (LAT) step();
      check_out("reset_release", 3'd7, 1'b1, 1'b0);

      apply("disabled", 1'b0, 8'h80, 3'd0, 1'b0, 1'b0);
      apply("disabled_ff", 1'b0, 8'hFF, 3'd0, 1'b0, 1'b0);
      apply("idle", 1'b1, 8'h00, 3'd0, 1'b0, 1'b1);

      // Walking one, one new vector per cycle.
      EI = 1'b1;
      for (int k = 0; k < 8 + LAT - 1; k++) begin
         if (k < 8) I = 8'(1 << k);
         step();
         if (k >= LAT - 1) begin
            check("walk.Y", 32'(Y), 32'(k - (LAT - 1)));
            check("walk.GS", 32'(GS), 32'd1);
            check("walk.EO", 32'(EO), 32'd0);
         end
      end

      apply("prio_13", 1'b1, 8'b0001_0011, 3'd4, 1'b1, 1'b0);
      apply("prio_03", 1'b1, 8'b0000_0011, 3'd1, 1'b1, 1'b0);
      apply("prio_01", 1'b1, 8'b0000_0001, 3'd0, 1'b1, 1'b0);
      apply("prio_a5", 1'b1, 8'b1010_0101, 3'd7, 1'b1, 1'b0);
      apply("prio_2c", 1'b1, 8'b0010_1100, 3'd5, 1'b1, 1'b0);

      // Mid-stream reset with 8'h40 streaming.
      apply("stream", 1'b1, 8'h40, 3'd6, 1'b1, 1'b0);
      rst = 1'b1;
      step();
      check_out("midrst", 3'd0, 1'b0, 1'b0);
      rst = 1'b0;
      for (int c = 1; c < LAT; c++) begin
         step();
         check_out("midrst_pipe", 3'd0, 1'b0, 1'b0);
      end
      step();
      check_out("midrst_resume", 3'd6, 1'b1, 1'b0);
      step();
      check_out("midrst_steady", 3'd6, 1'b1, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
